spi_burst_arbiter: RTL
======================

# spi_burst_arbiter

Round-robin arbiter and burst sequencer that shares one continuous-mode SPI controller among `N_REQ` requesters. A granted requester runs an `L`-byte transaction with chip select held low across all bytes. The block drives the controller's `trigger`/`data_in` so that each next byte is staged before the current byte ends. It routes received bytes back to the owning requester. It sits between the per-peripheral clients (SD, DAC, config) and the single SPI controller instance.

## Interface
- `N_REQ`, default 2: number of requesters, range 2..8.
- `DATA_WIDTH`, default 8: byte width; must match the SPI controller.
- `LEN_W`, default 8: width of the per-request length field.
- `GAP_CYCLES`, default 2: minimum cycles with `spi_cs` high between consecutive transactions, range ≥1.
- `clk` in 1: system clock (100 MHz).
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in N_REQ: per-requester transaction request; level, held until `done`.
- `len` in N_REQ*LEN_W: per-requester byte count; slice i = `len[i*LEN_W +: LEN_W]`; sampled at grant.
- `tx_data` in N_REQ*DATA_WIDTH: per-requester first-word-fall-through byte stream head.
- `tx_pop` out N_REQ: one-cycle pulse; the head byte was consumed, so the next byte is presented the following cycle.
- `rx_data` out DATA_WIDTH: received byte, broadcast to all requesters.
- `rx_valid` out N_REQ: one-cycle pulse to the owner when `rx_data` is valid.
- `done` out N_REQ: one-cycle pulse to the owner after its last byte is received.
- `grant` out N_REQ: one-hot owner, or zero when idle.
- `busy` out 1: high in any state except IDLE.
- `spi_data_in` out DATA_WIDTH: byte staged for the controller.
- `spi_trigger` out 1: controller trigger.
- `spi_data_out` in DATA_WIDTH: byte received from the controller.
- `spi_data_valid` in 1: controller byte-complete pulse.
- `spi_cs` in 1: controller chip select, active low; used as the controller-idle indication.

## Operation
- All outputs are registered.
- On reset, every output is 0; the state is IDLE and the round-robin pointer is 0.
- The controller must share `rst_n`.
- States: IDLE, START, PRELOAD, BURST, GAP.
- **IDLE:**
  - When any `req` is high and `spi_cs`=1, pick the first set `req` starting at index `ptr` (wrapping). Call it `g`.
  - Set `grant[g]`=1 and `ptr`<=g+1 mod N_REQ.
  - Latch `L` = len[g].
  - If L=0: pulse `done[g]`, no SPI activity, then go to GAP.
  - Else go to START.
- **START (one cycle):**
  - Drive `spi_trigger`=1 and `spi_data_in`<=tx_data[g].
  - Pulse `tx_pop[g]`.
  - Set `launch_left`=L-1 and `rx_left`=L.
  - Go to PRELOAD.
- **PRELOAD (one cycle):**
  - If `launch_left`>0, load `spi_data_in`<=tx_data[g] and pulse `tx_pop[g]`.
  - Go to BURST.
- **BURST:**
  - `spi_trigger` = (`launch_left`>0) at all times.
  - On `spi_data_valid`:
    - Drive `rx_data`<=spi_data_out and pulse `rx_valid[g]`.
    - Decrement `rx_left`.
    - If `launch_left`>0, decrement it; if the decremented value is still >0, load `spi_data_in` from tx_data[g] and pulse `tx_pop[g]`.
    - If `rx_left` was 1: pulse `done[g]`, drop `grant`, go to GAP.
- **GAP:**
  - Count consecutive cycles with `spi_cs`=1.
  - After `GAP_CYCLES` such cycles, go to IDLE.
- Total `tx_pop` pulses per transaction = L exactly. Total `rx_valid` pulses = L.
- Deasserting `req[g]` mid-burst is ignored; the burst completes.
- `len` and `tx_data` of non-granted requesters are don't-care.
- `spi_data_valid` outside BURST is ignored.
- Counters are LEN_W bits wide. L=2^LEN_W-1 must work without wrap.

## Timing
- `req` sampled at cycle T produces, at T+1: `grant`, `busy`, and the START outputs (`spi_trigger`=1, byte 0, `tx_pop`). The controller starts at T+2.
- `spi_trigger` falls at T+2 if L=1. Otherwise it stays high until the cycle after the (L-1)th `spi_data_valid`.
- Byte k+1 is on `spi_data_in` at least one full byte time before the controller samples it. This requires DATA_WIDTH*DATA_CLK_PERIOD ≥ 4.
- `rx_valid`/`rx_data` follow `spi_data_valid` by 1 cycle. `done` coincides with the last `rx_valid`.
- Back-to-back transactions have at least GAP_CYCLES+1 cycles of `spi_cs` high between them.
- Reset assertion mid-burst clears all outputs immediately (asynchronously). No `done` is issued. The pointer returns to 0.

## Test plan
- **Single byte:** req0 with L=1, tx 0xA5, cipo looped to copi → one `tx_pop[0]`, `spi_trigger` high for 1 cycle, `rx_data`=0xA5 with `rx_valid[0]`, `done[0]` on the same cycle, `spi_cs` low for exactly 1 byte.
- **Burst:** req1 with L=3, bytes 0x11, 0x22, 0x33, loopback → `spi_cs` continuously low for 3 bytes, `rx_data` sequence 0x11, 0x22, 0x33, 3 pops, `done[1]` after the third byte.
- **Fairness:** req0 and req1 held high together from reset, each with L=2 → grant order 0,1,0,1. Gaps between transactions are ≥GAP_CYCLES+1 cycles of `spi_cs` high. No `rx_valid` reaches the non-owner.
- **Zero length:** req0 with L=0 → `grant[0]` and `done[0]` pulse, no `spi_trigger`, no `tx_pop`; the next grant goes to req1.
- **Async reset:** `rst_n` low during byte 2 of an L=4 burst → `grant`, `busy`, `spi_trigger`, and all pulses are 0 immediately. After release, req1 is granted ahead of req0 (pointer = 0 and req0 low) per stimulus.
- **Max length:** L=255 with loopback → 255 `rx_valid` pulses, no counter wrap, single `done`.

Source files
------------

// File: rtl/spi_burst_arbiter_if.sv
// Bundle of requester-side and SPI-controller-side signals around spi_burst_arbiter.
// The arbiter takes the slave view; the requesters and controller together form the master view.
interface spi_burst_arbiter_if #(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = 8
);
  logic [N_REQ-1:0]            req;
  logic [N_REQ*LEN_W-1:0]      len;
  logic [N_REQ*DATA_WIDTH-1:0] tx_data;
  logic [N_REQ-1:0]            tx_pop;
  logic [DATA_WIDTH-1:0]       rx_data;
  logic [N_REQ-1:0]            rx_valid;
  logic [N_REQ-1:0]            done;
  logic [N_REQ-1:0]            grant;
  logic                        busy;
  logic [DATA_WIDTH-1:0]       spi_data_in;
  logic                        spi_trigger;
  logic [DATA_WIDTH-1:0]       spi_data_out;
  logic                        spi_data_valid;
  logic                        spi_cs;

  modport slave (
    input  req, len, tx_data, spi_data_out, spi_data_valid, spi_cs,
    output tx_pop, rx_data, rx_valid, done, grant, busy, spi_data_in, spi_trigger
  );

  modport master (
    output req, len, tx_data, spi_data_out, spi_data_valid, spi_cs,
    input  tx_pop, rx_data, rx_valid, done, grant, busy, spi_data_in, spi_trigger
  );
endinterface

// File: rtl/spi_burst_arbiter.sv
// Round-robin arbiter that runs one multi-byte, chip-select-held burst at a time on a
// shared continuous-mode SPI controller, staging each next byte one byte-time ahead.
module spi_burst_arbiter #(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = 8,
  parameter int GAP_CYCLES = 2
) (
  input logic               clk,
  input logic               rst_n,
  spi_burst_arbiter_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  typedef enum logic [2:0] {IDLE, START, PRELOAD, BURST, GAP} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        ptr;
  logic [IDX_W-1:0]        owner;
  logic [LEN_W-1:0]        launch_left;
  logic [LEN_W-1:0]        rx_left;
  logic [GAP_W-1:0]        gap_cnt;

  logic [N_REQ-1:0]        tx_pop_r;
  logic [N_REQ-1:0]        rx_valid_r;
  logic [N_REQ-1:0]        done_r;
  logic [N_REQ-1:0]        grant_r;
  logic                    busy_r;
  logic [DATA_WIDTH-1:0]   rx_data_r;
  logic [DATA_WIDTH-1:0]   spi_data_in_r;
  logic                    spi_trigger_r;

  logic [2*N_REQ-1:0]      req2;
  logic [N_REQ-1:0]        rot;
  logic                    found;
  int                      sum;
  logic [IDX_W-1:0]        pick;
  logic [IDX_W-1:0]        ptr_next;
  logic [N_REQ-1:0]        pick_hot;
  logic [N_REQ-1:0]        owner_hot;
  logic [LEN_W-1:0]        len_pick;
  logic [DATA_WIDTH-1:0]   pick_tx;
  logic [DATA_WIDTH-1:0]   owner_tx;
  logic [LEN_W-1:0]        launch_dec;

  // Rotate requests so bit 0 is the pointer position; the lowest set bit wins.
  always_comb begin
    req2  = {bus.req, bus.req};
    rot   = N_REQ'(req2 >> ptr);
    found = 1'b0;
    sum   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        sum   = int'(ptr) + k;
      end
    end
    pick = IDX_W'((sum >= N_REQ) ? (sum - N_REQ) : sum);
  end

  assign ptr_next   = (pick == IDX_W'(N_REQ - 1)) ? '0 : pick + IDX_W'(1);
  assign pick_hot   = N_REQ'(1) << pick;
  assign owner_hot  = N_REQ'(1) << owner;
  assign len_pick   = LEN_W'(bus.len >> (pick * LEN_W));
  assign pick_tx    = DATA_WIDTH'(bus.tx_data >> (pick * DATA_WIDTH));
  assign owner_tx   = DATA_WIDTH'(bus.tx_data >> (owner * DATA_WIDTH));
  assign launch_dec = launch_left - ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      owner         <= '0;
      launch_left   <= '0;
      rx_left       <= '0;
      gap_cnt       <= '0;
      tx_pop_r      <= '0;
      rx_valid_r    <= '0;
      done_r        <= '0;
      grant_r       <= '0;
      busy_r        <= 1'b0;
      rx_data_r     <= '0;
      spi_data_in_r <= '0;
      spi_trigger_r <= 1'b0;
    end else begin
      tx_pop_r   <= '0;
      rx_valid_r <= '0;
      done_r     <= '0;
      case (state)
        IDLE: begin
          if (found && bus.spi_cs) begin
            owner   <= pick;
            ptr     <= ptr_next;
            grant_r <= pick_hot;
            busy_r  <= 1'b1;
            if (len_pick == '0) begin
              done_r  <= pick_hot;
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              spi_trigger_r <= 1'b1;
              spi_data_in_r <= pick_tx;
              tx_pop_r      <= pick_hot;
              launch_left   <= len_pick - ONE;
              rx_left       <= len_pick;
              state         <= START;
            end
          end
        end
        START: begin
          spi_trigger_r <= (launch_left != '0);
          state         <= PRELOAD;
        end
        // Byte 1 is staged while byte 0 is still shifting so the controller never stalls.
        PRELOAD: begin
          if (launch_left != '0) begin
            spi_data_in_r <= owner_tx;
            tx_pop_r      <= owner_hot;
          end
          state <= BURST;
        end
        BURST: begin
          if (bus.spi_data_valid) begin
            rx_data_r  <= bus.spi_data_out;
            rx_valid_r <= owner_hot;
            rx_left    <= rx_left - ONE;
            if (launch_left != '0) begin
              launch_left   <= launch_dec;
              spi_trigger_r <= (launch_dec != '0);
              if (launch_dec != '0) begin
                spi_data_in_r <= owner_tx;
                tx_pop_r      <= owner_hot;
              end
            end
            if (rx_left == ONE) begin
              done_r  <= owner_hot;
              grant_r <= '0;
              gap_cnt <= '0;
              state   <= GAP;
            end
          end
        end
        // Only uninterrupted runs of an idle controller count toward the gap.
        GAP: begin
          grant_r <= '0;
          if (bus.spi_cs) begin
            if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
              busy_r <= 1'b0;
              state  <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end else begin
            gap_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_pop      = tx_pop_r;
  assign bus.rx_valid    = rx_valid_r;
  assign bus.done        = done_r;
  assign bus.grant       = grant_r;
  assign bus.busy        = busy_r;
  assign bus.rx_data     = rx_data_r;
  assign bus.spi_data_in = spi_data_in_r;
  assign bus.spi_trigger = spi_trigger_r;
endmodule
